// File: rtl/div_pkg.sv
// Shared types and constants for the divider request front end.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   // All-ones quotient returned for a zero divisor; sign-extend when widening.
   localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_FIX   = 3'd3,
      ST_RESP  = 3'd4
   } div_state_e;

   typedef struct packed {
      logic dz;
      logic timeout;
   } rsp_flags_t;

endpackage

// File: rtl/div_sign_fix.sv
// Operand magnitude and result sign correction for signed division.
// Only instantiated when SIGNED_DIV_EN is defined.
module div_sign_fix
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   input  logic             i_neg_q,
   input  logic             i_neg_r,
   input  logic [WIDTH-1:0] i_quotient,
   input  logic [WIDTH-1:0] i_remainder,
   output logic [WIDTH-1:0] o_dividend_mag,
   output logic [WIDTH-1:0] o_divisor_mag,
   output logic             o_neg_q,
   output logic             o_neg_r,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   logic w_a_neg;
   logic w_b_neg;

   assign w_a_neg = i_signed & i_dividend[WIDTH-1];
   assign w_b_neg = i_signed & i_divisor[WIDTH-1];

   // Modulo negation: the most negative value maps onto itself, which the
   // unsigned divider then treats as 2^(WIDTH-1).
   assign o_dividend_mag = w_a_neg ? (~i_dividend + WIDTH'(1)) : i_dividend;
   assign o_divisor_mag  = w_b_neg ? (~i_divisor + WIDTH'(1)) : i_divisor;

   assign o_neg_q = w_a_neg ^ w_b_neg;
   assign o_neg_r = w_a_neg;

   assign o_quotient  = i_neg_q ? (~i_quotient + WIDTH'(1)) : i_quotient;
   assign o_remainder = i_neg_r ? (~i_remainder + WIDTH'(1)) : i_remainder;

endmodule

// File: rtl/div_issue_ctrl.sv
// Request-side front end for the iterative divider: accept, issue, watchdog, sign fix, respond.
// Define SIGNED_DIV_EN to honour req_signed; otherwise all division is unsigned.
module div_issue_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH   = DIV_WIDTH,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_dividend,
   input  logic [WIDTH-1:0] req_divisor,
   input  logic             req_signed,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_quotient,
   output logic [WIDTH-1:0] rsp_remainder,
   output logic             rsp_dz,
   output logic             rsp_timeout,
   output logic             div_run,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   input  logic             div_ready,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder,
   output logic [2:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; valid never waits on ready, and payload is stable while
   // valid is high and unaccepted.

   localparam int CW = $clog2(TIMEOUT + 1);

   div_state_e       r_state;
   div_state_e       w_state_nxt;
   logic [CW-1:0]    r_wdog;
   logic [WIDTH-1:0] r_div_dividend;
   logic [WIDTH-1:0] r_div_divisor;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   rsp_flags_t       r_flags;

   logic             w_accept;
   logic             w_div_zero;
   logic             w_div_done;
   logic             w_wdog_exp;
   logic [WIDTH-1:0] w_mag_dividend;
   logic [WIDTH-1:0] w_mag_divisor;
   logic [WIDTH-1:0] w_fix_quot;
   logic [WIDTH-1:0] w_fix_rem;

   assign w_accept   = (r_state == ST_IDLE) && req_valid;
   assign w_div_zero = (req_divisor == '0);
   // A zero watchdog count marks the first WAIT cycle, where div_ready may
   // still reflect the previous operation.
   assign w_div_done = div_ready && (r_wdog != '0);
   assign w_wdog_exp = (r_wdog == CW'(TIMEOUT - 1));

`ifdef SIGNED_DIV_EN
   logic r_neg_q;
   logic r_neg_r;
   logic w_neg_q;
   logic w_neg_r;

   div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .i_signed       (req_signed),
      .i_dividend     (req_dividend),
      .i_divisor      (req_divisor),
      .i_neg_q        (r_neg_q),
      .i_neg_r        (r_neg_r),
      .i_quotient     (r_quot),
      .i_remainder    (r_rem),
      .o_dividend_mag (w_mag_dividend),
      .o_divisor_mag  (w_mag_divisor),
      .o_neg_q        (w_neg_q),
      .o_neg_r        (w_neg_r),
      .o_quotient     (w_fix_quot),
      .o_remainder    (w_fix_rem)
   );

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_neg_q <= w_neg_q;
         r_neg_r <= w_neg_r;
      end
   end
`else
   logic w_unused_signed;

   assign w_unused_signed = req_signed;
   assign w_mag_dividend  = req_dividend;
   assign w_mag_divisor   = req_divisor;
   assign w_fix_quot      = r_quot;
   assign w_fix_rem       = r_rem;
`endif

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_state_nxt = w_div_zero ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (w_div_done) begin
               w_state_nxt = ST_FIX;
            end else if (w_wdog_exp) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_FIX: w_state_nxt = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      div_run   = 1'b0;
      case (r_state)
         ST_IDLE:  req_ready = 1'b1;
         ST_ISSUE: div_run   = 1'b1;
         ST_RESP:  rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Result registers double as the capture stage: WAIT loads the raw
   // divider output, FIX rewrites it in place with the corrected value.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_wdog         <= '0;
         r_div_dividend <= '0;
         r_div_divisor  <= '0;
         r_quot         <= '0;
         r_rem          <= '0;
         r_flags        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_div_dividend <= w_mag_dividend;
                  r_div_divisor  <= w_mag_divisor;
                  r_flags        <= '0;
                  if (w_div_zero) begin
                     r_quot     <= WIDTH'(signed'(DZ_QUOTIENT));
                     r_rem      <= req_dividend;
                     r_flags.dz <= 1'b1;
                  end
               end
            end
            ST_ISSUE: r_wdog <= '0;
            ST_WAIT: begin
               r_wdog <= r_wdog + CW'(1);
               if (w_div_done) begin
                  r_quot <= div_quotient;
                  r_rem  <= div_remainder;
               end else if (w_wdog_exp) begin
                  r_quot          <= '0;
                  r_rem           <= '0;
                  r_flags.timeout <= 1'b1;
               end
            end
            ST_FIX: begin
               r_quot <= w_fix_quot;
               r_rem  <= w_fix_rem;
            end
            default: ;
         endcase
      end
   end

   assign rsp_quotient  = r_quot;
   assign rsp_remainder = r_rem;
   assign rsp_dz        = r_flags.dz;
   assign rsp_timeout   = r_flags.timeout;
   assign div_dividend  = r_div_dividend;
   assign div_divisor   = r_div_divisor;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed timing cases plus random traffic against a reference model.
module tb_div_issue_ctrl;

  localparam int W  = 32;
  localparam int TO = 64;
`ifdef SIGNED_DIV_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic          clk;
  logic          Reset;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_dividend;
  logic [W-1:0]  req_divisor;
  logic          req_signed;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_quotient;
  logic [W-1:0]  rsp_remainder;
  logic          rsp_dz;
  logic          rsp_timeout;
  logic          div_run;
  logic [W-1:0]  div_dividend;
  logic [W-1:0]  div_divisor;
  logic          div_ready;
  logic [W-1:0]  div_quotient;
  logic [W-1:0]  div_remainder;
  logic [2:0]    dbg_state;

  int            n_checks;
  int            n_errors;
  logic [65:0]   exp_q[$];
  bit            auto_rdy;
  bit            no_ready;
  bit            run_seen;
  int            div_lat;

  div_issue_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_signed    (req_signed),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_dz        (rsp_dz),
    .rsp_timeout   (rsp_timeout),
    .div_run       (div_run),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_ready     (div_ready),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // Reference: quotient truncates toward zero, remainder follows the dividend.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sa;
    int sb;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (SIGNED_EN && s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      sa = a;
      sb = b;
      return {32'(sa / sb), 32'(sa % sb)};
    end
    return {a / b, a % b};
  endfunction

  // ---------------- divider model ----------------
  initial begin
    logic [W-1:0] lat_a;
    logic [W-1:0] lat_b;
    bit           busy;
    int           cnt;
    busy = 0;
    cnt = 0;
    lat_a = '0;
    lat_b = '0;
    div_ready = 1'b0;
    div_quotient = '0;
    div_remainder = '0;
    forever begin
      @(negedge clk);
      if (Reset) begin
        busy = 0;
        div_ready = 1'b0;
      end else if (div_run) begin
        lat_a = div_dividend;
        lat_b = div_divisor;
        div_ready = 1'b0;
        busy = !no_ready;
        cnt = div_lat;
      end else if (busy) begin
        chk("div_operand_hold", {2'b00, div_dividend, div_divisor}, {2'b00, lat_a, lat_b});
        if (cnt == 0) begin
          div_quotient  = (lat_b != 0) ? lat_a / lat_b : '0;
          div_remainder = (lat_b != 0) ? lat_a % lat_b : '0;
          div_ready = 1'b1;
          busy = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // ---------------- response ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [65:0] held;
    logic [65:0] cur;
    logic [65:0] e;
    logic        prev_valid;
    logic        prev_run;
    prev_valid = 1'b0;
    prev_run = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (Reset) begin
        prev_valid = 1'b0;
        prev_run = 1'b0;
      end else begin
        if (div_run) begin
          run_seen = 1'b1;
          chk("div_run_pulse", {65'd0, prev_run}, 66'd0);
        end
        prev_run = div_run;
        cur = {rsp_quotient, rsp_remainder, rsp_dz, rsp_timeout};
        if (rsp_valid) begin
          if (prev_valid) chk("rsp_stable", cur, held);
          held = cur;
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL rsp_unexpected: got %h expected no response", cur);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_quotient", {34'd0, rsp_quotient}, {34'd0, e[65:34]});
              chk("rsp_remainder", {34'd0, rsp_remainder}, {34'd0, e[33:2]});
              chk("rsp_dz", {65'd0, rsp_dz}, {65'd0, e[1]});
              chk("rsp_timeout", {65'd0, rsp_timeout}, {65'd0, e[0]});
            end
          end
        end
        prev_valid = rsp_valid && !rsp_ready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input bit to_exp);
    logic [63:0] qr;
    int n;
    qr = ref_div(a, b, s);
    @(posedge clk);
    #1;
    req_dividend = a;
    req_divisor = b;
    req_signed = s;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_now("req_ready_wait");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (to_exp) exp_q.push_back({64'd0, 2'b01});
    else if (b == 32'd0) exp_q.push_back({qr, 2'b10});
    else exp_q.push_back({qr, 2'b00});
    #1;
    req_valid = 1'b0;
    req_dividend = $urandom;
    req_divisor = $urandom;
  endtask

  // Counts cycles from the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 300);
    if (!rsp_valid) fail_now("rsp_valid_wait");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_op(input bit is_divisor);
    case ($urandom_range(0, 7))
      0: return is_divisor ? 32'd0 : 32'h8000_0000;
      1: return 32'($urandom_range(1, 20));
      2: return 32'hFFFF_FFFF;
      3: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    n_checks = 0;
    n_errors = 0;
    auto_rdy = 0;
    no_ready = 0;
    run_seen = 0;
    div_lat = 0;
    Reset = 1'b1;
    req_valid = 1'b0;
    req_dividend = '0;
    req_divisor = '0;
    req_signed = 1'b0;
    rsp_ready = 1'b0;
    #12;
    chk("reset_req_ready", {65'd0, req_ready}, 66'd1);
    chk("reset_ctrl", {63'd0, rsp_valid, div_run, rsp_dz}, 66'd0);
    chk("reset_rsp", {rsp_quotient, rsp_remainder, 1'b0, rsp_timeout}, 66'd0);
    chk("reset_div_ops", {2'b00, div_dividend, div_divisor}, 66'd0);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    rsp_ready = 1'b1;

    // Unsigned 100/7 with the earliest possible divider completion.
    div_lat = 0;
    send(32'd100, 32'd7, 1'b0, 1'b0);
    wait_rsp(cyc);
    chk("latency_min", 66'(cyc), 66'd5);
    drain();

    // Divide by zero bypasses the divider.
    run_seen = 1'b0;
    send(32'h1234, 32'd0, 1'b0, 1'b0);
    wait_rsp(cyc);
    chk("latency_dz", 66'(cyc), 66'd1);
    drain();
    chk("dz_no_run", {65'd0, run_seen}, 66'd0);

    // Signed corner cases.
    div_lat = 3;
    send(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    drain();
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drain();
    send(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b0);
    drain();
    send(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    drain();

    // Backpressure: response held while rsp_ready stays low.
    rsp_ready = 1'b0;
    div_lat = 1;
    send(32'd1000, 32'd9, 1'b0, 1'b0);
    wait_rsp(cyc);
    repeat (5) begin
      @(negedge clk);
      chk("bp_busy", {64'd0, req_ready, rsp_valid}, 66'b01);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_after", {64'd0, req_ready, rsp_valid}, 66'b10);
    rsp_ready = 1'b1;
    drain();

    // Watchdog: divider never completes.
    no_ready = 1;
    send(32'd55, 32'd5, 1'b0, 1'b1);
    wait_rsp(cyc);
    chk("latency_timeout", 66'(cyc), 66'(TO + 2));
    drain();
    no_ready = 0;

    // Asynchronous reset during WAIT abandons the transaction.
    div_lat = 30;
    send(32'd77, 32'd3, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_req_ready", {65'd0, req_ready}, 66'd1);
    chk("async_rst_ctrl", {64'd0, rsp_valid, div_run}, 66'd0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    div_lat = 2;
    send(32'd1000, 32'd10, 1'b0, 1'b0);
    drain();

    // Random traffic with random response backpressure.
    auto_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      div_lat = $urandom_range(0, 6);
      send(pick_op(1'b0), pick_op(1'b1), 1'($urandom_range(0, 1)), 1'b0);
    end
    drain();
    auto_rdy = 0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("queue_empty", 66'(exp_q.size()), 66'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Request-side front end for the iterative 32-bit divider.
- Accepts divide requests over a valid/ready handshake and latches the operands.
- Converts signed operands to magnitudes, starts the divider with a one-cycle run pulse and waits for its completion.
- Applies sign correction and returns quotient and remainder over a valid/ready response handshake.
- Divide-by-zero bypasses the divider; a watchdog flags a divider that never completes.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- TIMEOUT, 64, max cycles to wait for divider Ready before aborting

Ports:
- clk  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_dividend  in  WIDTH  dividend
- req_divisor  in  WIDTH  divisor
- req_signed  in  1  treat operands as two's complement
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_quotient  out  WIDTH  final quotient
- rsp_remainder  out  WIDTH  final remainder
- rsp_dz  out  1  divisor was zero
- rsp_timeout  out  1  divider failed to complete
- div_run  out  1  start pulse to divider
- div_dividend  out  WIDTH  magnitude dividend to divider
- div_divisor  out  WIDTH  magnitude divisor to divider
- div_ready  in  1  divider done
- div_quotient  in  WIDTH  divider quotient
- div_remainder  in  WIDTH  divider remainder

## Operation
FSM states and transitions:
- IDLE: req_ready=1. On req_valid, latch operands, the sign flag and the result signs.
  - Divisor == 0: go to RESP.
  - Otherwise: go to ISSUE.
- ISSUE: div_run=1 for exactly one cycle, then go to WAIT. Clear the watchdog counter.
- WAIT: increment the watchdog each cycle.
  - div_ready=1 (ignored in the first WAIT cycle): capture the divider outputs, go to FIX.
  - Counter reaches TIMEOUT-1: set the timeout flag, go to RESP.
- FIX: apply sign correction, go to RESP.
- RESP: rsp_valid=1 with all rsp_* outputs held stable. On rsp_ready, return to IDLE.

Magnitude and sign rules:
- When the signed mode is active, each negative operand is sent as its two's-complement negation, in modulo 2^WIDTH arithmetic. 0x80000000 is sent as 0x80000000.
- Quotient is negated when the operand signs differ. Remainder takes the dividend's sign.
- Signed overflow (0x80000000 / 0xFFFFFFFF) falls out naturally: quotient 0x80000000, remainder 0.

Divide-by-zero and timeout results:
- Divide-by-zero: quotient all-ones, remainder = original dividend, rsp_dz=1.
- Timeout: quotient = remainder = 0, rsp_timeout=1.

Operand hold: div_dividend and div_divisor are registered and held constant from ISSUE until the block leaves WAIT.

Reset values: all outputs 0 except req_ready=1; state IDLE. Reset mid-operation abandons the transaction immediately; no response is produced.

## Timing
- Accept handshake completes at edge 0.
- div_run is high in cycle 1.
- Earliest div_ready sample is cycle 3; FIX is 1 cycle after capture; rsp_valid is high the following cycle.
- Divide-by-zero: rsp_valid in cycle 1.
- No new request while busy; req_ready=1 only in IDLE, so throughput is one transaction per division.
- rsp_valid stays high until rsp_ready; the rsp_* outputs may not change while rsp_valid=1.

## Configuration
- SIGNED_DIV_EN defined: req_signed is honoured and the sign-correction logic is built.
- Undefined: req_signed is ignored, all division is unsigned, FIX is a pass-through cycle with identical latency.

## Structure
- Shared package div_pkg:
  - state enum
  - WIDTH default
  - DZ_QUOTIENT all-ones constant
  - response flag typedef
- One sub-module, div_sign_fix: combinational operand-magnitude and result-sign correction, instantiated only under SIGNED_DIV_EN.

## Test plan
- Unsigned 100 / 7 -> rsp_quotient=14, rsp_remainder=2, rsp_dz=0; div_run is a single-cycle pulse.
- Dividend 0x1234, divisor 0 -> rsp_valid in cycle 1, quotient 0xFFFFFFFF, remainder 0x1234, rsp_dz=1, div_run never asserted.
- Signed -7 / 2 (0xFFFFFFF9 / 2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- rsp_ready held low for 5 cycles after rsp_valid -> outputs stable, req_ready=0, then IDLE one cycle after the handshake.
- div_ready tied 0 with TIMEOUT=64 -> rsp_timeout=1 with quotient 0, remainder 0, after 64 WAIT cycles.
- Reset asserted during WAIT -> req_ready=1, rsp_valid=0 and div_run=0 asynchronously; the next request completes correctly.
